lcd_pixel_unpacker: RTL and testbench
=====================================

Name: lcd_pixel_unpacker

Overview:
- Display-side counterpart of the HDMI packing path.
- Reads 32-bit words from the frame FIFO and unpacks them into a stream of 24-bit RGB pixels (R in [23:16], G in [15:8], B in [7:0], MSB first) for the LCD driver.
- Every 3 FIFO words yield 4 pixels.
- Tracks line and frame position and tags the last pixel of each line and frame.

Parameters:
- PIXELS_PER_LINE, 800, active pixels per line; must be at least 2.
- LINES_PER_FRAME, 480, active lines per frame; must be at least 1.

Ports:
- i_lcdClock  input  1  pixel-domain clock; all logic on its rising edge.
- i_lcdReset_n  input  1  reset, synchronous, active-low.
- i_frameStart  input  1  one-cycle pulse; realigns the unpacker to the start of a frame.
- i_fifoData  input  32  show-ahead FIFO output; valid whenever i_fifoEmpty is 0.
- i_fifoEmpty  input  1  FIFO empty flag.
- o_fifoRead  output  1  pop strobe; combinational.
- o_pixelData  output  24  registered pixel.
- o_pixelValid  output  1  o_pixelData holds a pixel.
- i_pixelReady  input  1  downstream accepts the pixel this cycle.
- o_lastInLine  output  1  registered; qualifies o_pixelData.
- o_lastInFrame  output  1  registered; qualifies o_pixelData.

Behaviour:
- Reset (i_lcdReset_n=0 at a clock edge) clears:
  - phase to 0 and residue to 0;
  - column and row counters to 0;
  - o_pixelData, o_pixelValid, o_lastInLine and o_lastInFrame to 0.
- o_fifoRead is 0 while reset is asserted.
- Output slot is free when o_pixelValid=0 or i_pixelReady=1.
- A load occurs when the slot is free and i_frameStart=0, and either phase=3 or i_fifoEmpty=0.
- Word packing (pixels P0..P3):
  - W0 = {P0, P1[23:16]}
  - W1 = {P1[15:0], P2[23:8]}
  - W2 = {P2[7:0], P3}
- Phase state machine, 2-bit, advances by 1 per load and wraps 3->0:
  - 0: pixel = W[31:8]; residue <= W[7:0]; pop.
  - 1: pixel = {residue[7:0], W[31:16]}; residue <= W[15:0]; pop.
  - 2: pixel = {residue[15:0], W[31:24]}; residue <= W[23:0]; pop.
  - 3: pixel = residue[23:0]; residue <= 0; no pop.
- o_fifoRead = load AND phase != 3. The FIFO is never popped while empty.
- Latency: a FIFO word is visible at o_pixelData on the clock edge after its load.
- Output holding: with o_pixelValid=1 and i_pixelReady=0, o_pixelData and both tags are held stable.
- No load on a cycle: o_pixelValid goes to 0 if i_pixelReady=1, otherwise holds.
- Counters, updated on each load:
  - o_lastInLine <= (column == PIXELS_PER_LINE-1).
  - o_lastInFrame <= o_lastInLine-condition AND (row == LINES_PER_FRAME-1).
  - Column wraps to 0 after PIXELS_PER_LINE-1; row increments on column wrap and wraps to 0 after LINES_PER_FRAME-1.
  - Phase is independent of line boundaries; no realignment at line end.
- i_frameStart takes priority over load:
  - phase, residue and counters go to 0; o_pixelValid goes to 0, dropping any held pixel; no pop that cycle.
  - If coincident with reset, reset wins; the effect is identical.
- Empty FIFO in phase 0-2: no load, no pop, state held. Phase 3 proceeds even when the FIFO is empty.

Optional Feature:
- Macro: LCD_UNPACKER_UNDERFLOW_EN.
- Defined:
  - Adds output port o_underflow (1 bit, registered, sticky).
  - Set when the slot is free, phase != 3, i_fifoEmpty=1, the counters are not both 0, and i_frameStart=0.
  - Cleared by reset or i_frameStart.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package lcd_pkg holds:
  - localparams PIXEL_W=24 and WORD_W=32;
  - phase encodings PH_0..PH_3;
  - default PIXELS_PER_LINE and LINES_PER_FRAME.
- One sub-module, lcd_position_counter, holds the column and row counters and the last-in-line/frame compare. It has a load enable and a synchronous clear (reset or i_frameStart).

Test Plan:
- Stream 3 words 0xAABBCC11, 0x2233DDEE, 0xFF445566 with i_pixelReady=1 -> pixels 0xAABBCC, 0x112233, 0xDDEEFF, 0x445566 on consecutive cycles; 3 pops; phase back to 0.
- Backpressure: i_pixelReady=0 for 5 cycles mid-stream -> o_pixelData and tags stable, o_fifoRead=0 throughout; the stream resumes with no loss or duplication.
- FIFO empty after W0 -> pixel P0 only, no pop while empty, o_pixelValid drops; refill W1 -> next pixel {W0[7:0], W1[31:16]}.
- With PIXELS_PER_LINE=4 and LINES_PER_FRAME=2, stream 8 pixels:
  - o_lastInLine is 1 on pixels 3 and 7;
  - o_lastInFrame is 1 on pixel 7 only;
  - counters wrap to 0.
- i_frameStart asserted in phase 2 with a valid pixel held -> o_pixelValid=0 next cycle, no pop; the next word unpacks as phase 0.
- With LCD_UNPACKER_UNDERFLOW_EN: empty FIFO at column 5 -> o_underflow=1 and stays 1; i_frameStart clears it. Empty at column 0 / row 0 -> no set.

Source files
------------

// File: rtl/lcd_pixel_unpacker_pkg.sv
// Shared definitions for the LCD pixel unpacker: bus widths, unpack phases
// and default frame geometry.
package lcd_pkg;

  localparam int PIXEL_W = 24;
  localparam int WORD_W  = 32;

  localparam int DEFAULT_PIXELS_PER_LINE = 800;
  localparam int DEFAULT_LINES_PER_FRAME = 480;

  // Four pixels span three FIFO words, so the unpacker cycles through four phases.
  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_t;

  function automatic int counterWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/lcd_pixel_unpacker_if.sv
// FIFO-side and pixel-side signals of the LCD pixel unpacker.
// o_underflow exists only when LCD_UNPACKER_UNDERFLOW_EN is defined.
interface lcd_pixel_unpacker_if;
  import lcd_pkg::*;

  logic               i_frameStart;
  logic [WORD_W-1:0]  i_fifoData;
  logic               i_fifoEmpty;
  logic               o_fifoRead;
  logic [PIXEL_W-1:0] o_pixelData;
  logic               o_pixelValid;
  logic               i_pixelReady;
  logic               o_lastInLine;
  logic               o_lastInFrame;
`ifdef LCD_UNPACKER_UNDERFLOW_EN
  logic               o_underflow;
`endif

  // The unpacker itself takes the master view; the FIFO and LCD driver side take the slave view.
  modport master (
    input  i_frameStart, i_fifoData, i_fifoEmpty, i_pixelReady,
    output o_fifoRead, o_pixelData, o_pixelValid, o_lastInLine, o_lastInFrame
`ifdef LCD_UNPACKER_UNDERFLOW_EN
    , output o_underflow
`endif
  );

  modport slave (
    output i_frameStart, i_fifoData, i_fifoEmpty, i_pixelReady,
    input  o_fifoRead, o_pixelData, o_pixelValid, o_lastInLine, o_lastInFrame
`ifdef LCD_UNPACKER_UNDERFLOW_EN
    , input o_underflow
`endif
  );

endinterface

// File: rtl/lcd_pixel_unpacker_position_counter.sv
// Column/row position of the next pixel to be loaded, with end-of-line and
// end-of-frame flags. atOrigin exists only with LCD_UNPACKER_UNDERFLOW_EN.
module lcd_position_counter
  import lcd_pkg::*;
#(
  parameter int PIXELS_PER_LINE = DEFAULT_PIXELS_PER_LINE,
  parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) (
  input  logic lcdClock,
  input  logic clear,
  input  logic advance,
  output logic lineEnd,
  output logic frameEnd
`ifdef LCD_UNPACKER_UNDERFLOW_EN
  , output logic atOrigin
`endif
);

  localparam int COL_W = counterWidth(PIXELS_PER_LINE);
  localparam int ROW_W = counterWidth(LINES_PER_FRAME);

  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row;

  assign lineEnd  = (column == COL_W'(PIXELS_PER_LINE - 1));
  assign frameEnd = lineEnd && (row == ROW_W'(LINES_PER_FRAME - 1));
`ifdef LCD_UNPACKER_UNDERFLOW_EN
  assign atOrigin = (column == '0) && (row == '0);
`endif

  // Clear covers both reset and frame realignment, so it outranks advance.
  always_ff @(posedge lcdClock) begin
    if (clear) begin
      column <= '0;
      row    <= '0;
    end else if (advance) begin
      if (lineEnd) begin
        column <= '0;
        row    <= frameEnd ? '0 : row + 1'b1;
      end else begin
        column <= column + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// Unpacks 32-bit frame FIFO words into 24-bit RGB pixels (3 words -> 4 pixels)
// with line/frame tags. Optional sticky underflow flag: LCD_UNPACKER_UNDERFLOW_EN.
module lcd_pixel_unpacker
  import lcd_pkg::*;
#(
  parameter int PIXELS_PER_LINE = DEFAULT_PIXELS_PER_LINE,
  parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME
) (
  input logic                  i_lcdClock,
  input logic                  i_lcdReset_n,
  lcd_pixel_unpacker_if.master bus
);

  phase_t             phase, phaseNext;
  logic [PIXEL_W-1:0] residue, residueNext;
  logic [PIXEL_W-1:0] pixelData, pixelDataNext;
  logic               pixelValid, pixelValidNext;
  logic               lastInLine, lastInLineNext;
  logic               lastInFrame, lastInFrameNext;
  logic [PIXEL_W-1:0] unpacked, residueLoad;
  logic [WORD_W-1:0]  fifoWord;
  logic               slotFree, load;
  logic               lineEnd, frameEnd, counterClear;
`ifdef LCD_UNPACKER_UNDERFLOW_EN
  logic               atOrigin, underflow, underflowNext;
`endif

  assign fifoWord     = bus.i_fifoData;
  assign slotFree     = !pixelValid || bus.i_pixelReady;
  assign load         = slotFree && !bus.i_frameStart && (phase == PH_3 || !bus.i_fifoEmpty);
  assign counterClear = !i_lcdReset_n || bus.i_frameStart;

  assign bus.o_fifoRead    = i_lcdReset_n && load && (phase != PH_3);
  assign bus.o_pixelData   = pixelData;
  assign bus.o_pixelValid  = pixelValid;
  assign bus.o_lastInLine  = lastInLine;
  assign bus.o_lastInFrame = lastInFrame;

  lcd_position_counter #(
    .PIXELS_PER_LINE (PIXELS_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) positionCounter (
    .lcdClock (i_lcdClock),
    .clear    (counterClear),
    .advance  (load),
    .lineEnd  (lineEnd),
    .frameEnd (frameEnd)
`ifdef LCD_UNPACKER_UNDERFLOW_EN
    , .atOrigin (atOrigin)
`endif
  );

  always_ff @(posedge i_lcdClock) begin
    if (!i_lcdReset_n) begin
      phase       <= PH_0;
      residue     <= '0;
      pixelData   <= '0;
      pixelValid  <= 1'b0;
      lastInLine  <= 1'b0;
      lastInFrame <= 1'b0;
    end else begin
      phase       <= phaseNext;
      residue     <= residueNext;
      pixelData   <= pixelDataNext;
      pixelValid  <= pixelValidNext;
      lastInLine  <= lastInLineNext;
      lastInFrame <= lastInFrameNext;
    end
  end

  // Residue carries the bytes of the current word not yet emitted; phase 3 drains it without a pop.
  always_comb begin
    unpacked        = '0;
    residueLoad     = '0;
    phaseNext       = phase;
    residueNext     = residue;
    pixelDataNext   = pixelData;
    pixelValidNext  = pixelValid;
    lastInLineNext  = lastInLine;
    lastInFrameNext = lastInFrame;

    case (phase)
      PH_0: begin
        unpacked    = fifoWord[31:8];
        residueLoad = {16'd0, fifoWord[7:0]};
      end
      PH_1: begin
        unpacked    = {residue[7:0], fifoWord[31:16]};
        residueLoad = {8'd0, fifoWord[15:0]};
      end
      PH_2: begin
        unpacked    = {residue[15:0], fifoWord[31:24]};
        residueLoad = fifoWord[23:0];
      end
      default: begin
        unpacked    = residue;
        residueLoad = '0;
      end
    endcase

    if (bus.i_frameStart) begin
      phaseNext      = PH_0;
      residueNext    = '0;
      pixelValidNext = 1'b0;
    end else if (load) begin
      phaseNext       = phase_t'(phase + 2'd1);
      residueNext     = residueLoad;
      pixelDataNext   = unpacked;
      pixelValidNext  = 1'b1;
      lastInLineNext  = lineEnd;
      lastInFrameNext = frameEnd;
    end else if (bus.i_pixelReady) begin
      pixelValidNext = 1'b0;
    end
  end

`ifdef LCD_UNPACKER_UNDERFLOW_EN
  // Starving at the very start of a frame is expected, so only mid-frame starvation counts.
  always_comb begin
    underflowNext = underflow;
    if (bus.i_frameStart) begin
      underflowNext = 1'b0;
    end else if (slotFree && phase != PH_3 && bus.i_fifoEmpty && !atOrigin) begin
      underflowNext = 1'b1;
    end
  end

  always_ff @(posedge i_lcdClock) begin
    if (!i_lcdReset_n) begin
      underflow <= 1'b0;
    end else begin
      underflow <= underflowNext;
    end
  end

  assign bus.o_underflow = underflow;
`endif

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Self-checking bench for lcd_pixel_unpacker: table vectors, corner sequences
// and random traffic against a byte-stream reference model.
module tb_lcd_pixel_unpacker;
  import lcd_pkg::*;

  localparam int PPL = 4;
  localparam int LPF = 2;

  typedef struct packed {
    logic [2:0][31:0] words;
    logic [3:0][23:0] pixels;
  } vecT;

  logic lcdClock   = 1'b0;
  logic lcdReset_n = 1'b0;

  lcd_pixel_unpacker_if bus();

  lcd_pixel_unpacker #(
    .PIXELS_PER_LINE (PPL),
    .LINES_PER_FRAME (LPF)
  ) dut (
    .i_lcdClock   (lcdClock),
    .i_lcdReset_n (lcdReset_n),
    .bus          (bus)
  );

  always #5 lcdClock = ~lcdClock;

  int checks = 0;
  int errors = 0;

  // The model sees the frame as a plain byte stream: pixel k is bytes 3k..3k+2.
  logic [31:0] wordQ[$];
  logic [7:0]  byteQ[$];
  int          pixIdx = 0;
  int          alignWords = 0;
  logic [23:0] gotQ[$];
  logic        gotLine[$];
  logic        gotFrame[$];

  vecT vecs[3];

  function automatic vecT mkVec(input logic [31:0] w0, w1, w2,
                                input logic [23:0] p0, p1, p2, p3);
    vecT v;
    v.words[0]  = w0;
    v.words[1]  = w1;
    v.words[2]  = w2;
    v.pixels[0] = p0;
    v.pixels[1] = p1;
    v.pixels[2] = p2;
    v.pixels[3] = p3;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    wordQ.push_back(w);
    for (int b = 3; b >= 0; b--) byteQ.push_back(w[b*8 +: 8]);
    alignWords++;
  endtask

  // After a frame start the unpacker restarts at the next unpopped word.
  task automatic realignModel();
    byteQ.delete();
    foreach (wordQ[i]) for (int b = 3; b >= 0; b--) byteQ.push_back(wordQ[i][b*8 +: 8]);
    pixIdx     = 0;
    alignWords = wordQ.size();
  endtask

  // One clock: drive at the falling edge, check after settling, model the FIFO pop at the rising edge.
  task automatic applyStimulus(input logic ready, input logic allowData, input logic frameStart);
    logic        emptyNow, popNow, expLine, expFrame;
    logic [23:0] expPix;
    @(negedge lcdClock);
    emptyNow          = !allowData || (wordQ.size() == 0);
    bus.i_pixelReady  = ready;
    bus.i_frameStart  = frameStart;
    bus.i_fifoEmpty   = emptyNow;
    bus.i_fifoData    = emptyNow ? $urandom() : wordQ[0];
    #1;
    popNow = bus.o_fifoRead;
    if (emptyNow)                          checkOutput("popWhileEmpty", {31'd0, popNow}, 32'd0);
    else if (frameStart)                   checkOutput("popOnFrameStart", {31'd0, popNow}, 32'd0);
    else if (bus.o_pixelValid && !ready)   checkOutput("popWhileStalled", {31'd0, popNow}, 32'd0);
    if (bus.o_pixelValid) begin
      if (byteQ.size() < 3) begin
        checks++;
        errors++;
        $display("[TB] FAIL extraPixel: actual=0x%0h required=no pixel", bus.o_pixelData);
      end else begin
        expPix   = {byteQ[0], byteQ[1], byteQ[2]};
        expLine  = (pixIdx % PPL) == PPL - 1;
        expFrame = (pixIdx % (PPL * LPF)) == PPL * LPF - 1;
        checkOutput("pixel", {6'd0, bus.o_lastInFrame, bus.o_lastInLine, bus.o_pixelData},
                    {6'd0, expFrame, expLine, expPix});
        if (ready && !frameStart) begin
          repeat (3) void'(byteQ.pop_front());
          pixIdx++;
          gotQ.push_back(bus.o_pixelData);
          gotLine.push_back(bus.o_lastInLine);
          gotFrame.push_back(bus.o_lastInFrame);
        end
      end
    end
    @(posedge lcdClock);
    if (popNow && wordQ.size() > 0) void'(wordQ.pop_front());
    if (frameStart) realignModel();
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(wordQ.size() == 0 && byteQ.size() < 3 && !bus.o_pixelValid) && n < budget) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drainInBudget", {31'd0, n < budget}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    logic [7:0]  lineExp;
    logic [7:0]  frameExp;
    logic        fs;

    vecs[0] = mkVec(32'hAABBCC11, 32'h2233DDEE, 32'hFF445566,
                    24'hAABBCC, 24'h112233, 24'hDDEEFF, 24'h445566);
    vecs[1] = mkVec(32'h01020304, 32'h05060708, 32'h090A0B0C,
                    24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    vecs[2] = mkVec(32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678,
                    24'hDEADBE, 24'hEFCAFE, 24'hF00D12, 24'h345678);

    // Reset with a non-empty FIFO: no pop, all outputs cleared.
    bus.i_frameStart = 1'b0;
    bus.i_fifoEmpty  = 1'b0;
    bus.i_fifoData   = 32'h12345678;
    bus.i_pixelReady = 1'b1;
    repeat (3) @(negedge lcdClock);
    #1;
    checkOutput("resetFifoRead", {31'd0, bus.o_fifoRead}, 32'd0);
    checkOutput("resetValid", {31'd0, bus.o_pixelValid}, 32'd0);
    checkOutput("resetData", {8'd0, bus.o_pixelData}, 32'd0);
    checkOutput("resetLastInLine", {31'd0, bus.o_lastInLine}, 32'd0);
    checkOutput("resetLastInFrame", {31'd0, bus.o_lastInFrame}, 32'd0);
`ifdef LCD_UNPACKER_UNDERFLOW_EN
    checkOutput("resetUnderflow", {31'd0, bus.o_underflow}, 32'd0);
`endif
    bus.i_fifoEmpty = 1'b1;
    lcdReset_n      = 1'b1;

    // Table vectors at full throughput.
    for (int v = 0; v < 3; v++) begin
      base = gotQ.size();
      for (int w = 0; w < 3; w++) pushWord(vecs[v].words[w]);
      drain(40);
      checkOutput("vecPixelCount", 32'(gotQ.size() - base), 32'd4);
      if (gotQ.size() >= base + 4)
        for (int j = 0; j < 4; j++) checkOutput("vecPixel", {8'd0, gotQ[base + j]}, {8'd0, vecs[v].pixels[j]});
    end

    // Backpressure mid-stream for five cycles.
    base = gotQ.size();
    pushWord(32'h10203040); pushWord(32'h50607080); pushWord(32'h90A0B0C0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    drain(40);
    checkOutput("stallPixelCount", 32'(gotQ.size() - base), 32'd4);

    // FIFO empties after the first word, then refills.
    base = gotQ.size();
    pushWord(32'hA1B2C3D4);
    drain(20);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("validAfterEmpty", {31'd0, bus.o_pixelValid}, 32'd0);
    pushWord(32'hE5F60718); pushWord(32'h293A4B5C);
    drain(40);
    checkOutput("emptyPixelCount", 32'(gotQ.size() - base), 32'd4);
    if (gotQ.size() >= base + 2) begin
      checkOutput("emptyP0", {8'd0, gotQ[base]}, 32'h00A1B2C3);
      checkOutput("emptyP1", {8'd0, gotQ[base + 1]}, 32'h00D4E5F6);
    end

    // Line/frame tags over two 4-pixel lines, then wrap.
    applyStimulus(1'b0, 1'b1, 1'b1);
    base = gotQ.size();
    repeat (9) pushWord($urandom());
    drain(80);
    checkOutput("tagPixelCount", 32'(gotQ.size() - base), 32'd12);
    lineExp  = 8'b1000_1000;
    frameExp = 8'b1000_0000;
    if (gotQ.size() >= base + 12) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput("lastInLine", {31'd0, gotLine[base + i]}, {31'd0, lineExp[i]});
        checkOutput("lastInFrame", {31'd0, gotFrame[base + i]}, {31'd0, frameExp[i]});
      end
      checkOutput("wrapLastInLine", {31'd0, gotLine[base + 11]}, 32'd1);
      checkOutput("wrapLastInFrame", {31'd0, gotFrame[base + 11]}, 32'd0);
    end

    // Frame start in phase 2 while a pixel is held.
    pushWord(32'h11223344); pushWord(32'h55667788); pushWord(32'h99AABBCC);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("frameStartDropsValid", {31'd0, bus.o_pixelValid}, 32'd0);
    base = gotQ.size();
    pushWord(32'h0D0E0F10); pushWord(32'h11121314);
    drain(40);
    checkOutput("realignPixelCount", 32'(gotQ.size() - base), 32'd4);
    if (gotQ.size() > base) checkOutput("realignFirstPixel", {8'd0, gotQ[base]}, 32'h0099AABB);

`ifdef LCD_UNPACKER_UNDERFLOW_EN
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("underflowAtOrigin", {31'd0, bus.o_underflow}, 32'd0);
    pushWord(32'h01020304);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("underflowSet", {31'd0, bus.o_underflow}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("underflowSticky", {31'd0, bus.o_underflow}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("underflowCleared", {31'd0, bus.o_underflow}, 32'd0);
`endif

    // Random traffic with occasional frame starts.
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 400; c++) begin
      if (wordQ.size() < 4 && $urandom_range(2) != 0) pushWord($urandom());
      fs = ($urandom_range(60) == 0);
      applyStimulus(fs ? 1'b0 : 1'($urandom_range(1)), 1'($urandom_range(3) != 0), fs);
    end
    while (alignWords % 3 != 0) pushWord($urandom());
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
